// File: rtl/id_stage_pkg.sv
// Opcode/funct constants and operand-select encodings for the RV32I decode stage.
package id_stage_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
    localparam logic [6:0] INST_TYPE_L   = 7'b0000011;
    localparam logic [6:0] INST_TYPE_S   = 7'b0100011;
    localparam logic [6:0] INST_TYPE_B   = 7'b1100011;
    localparam logic [6:0] INST_JAL      = 7'b1101111;
    localparam logic [6:0] INST_JALR     = 7'b1100111;
    localparam logic [6:0] INST_LUI      = 7'b0110111;
    localparam logic [6:0] INST_AUIPC    = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_LB      = 3'b000;
    localparam logic [2:0] F3_LH      = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_LBU     = 3'b100;
    localparam logic [2:0] F3_LHU     = 3'b101;
    localparam logic [2:0] F3_SB      = 3'b000;
    localparam logic [2:0] F3_SH      = 3'b001;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
    typedef enum logic [1:0] {OP2_RS2, OP2_IMM, OP2_FOUR, OP2_ZERO} op2_sel_e;

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I decoder: immediate, operand selects, rd/wen, register use, illegal.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage owns the handshake.
module id_decode
    import id_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = 5
) (
    input  logic [31:0]        inst_i,
    output logic [XLEN-1:0]    imm_o,
    output op1_sel_e           op1_sel_o,
    output op2_sel_e           op2_sel_o,
    output logic               rs2v_rs1_o,
    output logic               uses_rs1_o,
    output logic               uses_rs2_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               reg_wen_o,
    output logic               illegal_o
);
    logic [6:0]         opcode;
    logic [6:0]         funct7;
    logic [2:0]         funct3;
    logic [31:0]        imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic [RADDR_W-1:0] rd_raw;
    logic               writes;
    logic               legal;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign rd_raw = inst_i[7 +: RADDR_W];

    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    always_comb begin
        imm32      = '0;
        op1_sel_o  = OP1_ZERO;
        op2_sel_o  = OP2_ZERO;
        rs2v_rs1_o = 1'b0;
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
        writes     = 1'b0;
        legal      = 1'b1;
        case (opcode)
            INST_TYPE_R_M: begin
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && (funct3 == F3_ADD_SUB || funct3 == F3_SR));
                op1_sel_o = OP1_RS1; op2_sel_o = OP2_RS2;
                uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; writes = 1'b1;
            end
            INST_TYPE_I: begin
                if (funct3 == F3_SLL)     legal = (funct7 == F7_BASE);
                else if (funct3 == F3_SR) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                imm32 = imm_i; op1_sel_o = OP1_RS1; op2_sel_o = OP2_IMM;
                uses_rs1_o = 1'b1; writes = 1'b1;
            end
            INST_TYPE_L: begin
                legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
                imm32 = imm_i; op1_sel_o = OP1_RS1; op2_sel_o = OP2_IMM;
                uses_rs1_o = 1'b1; writes = 1'b1;
            end
            INST_TYPE_S: begin
                legal = funct3 inside {F3_SB, F3_SH, F3_SW};
                imm32 = imm_s; op1_sel_o = OP1_RS1; op2_sel_o = OP2_IMM;
                uses_rs1_o = 1'b1; uses_rs2_o = 1'b1;
            end
            INST_TYPE_B: begin
                // funct3 010/011 are unassigned branch encodings
                legal = (funct3[2:1] != 2'b01);
                imm32 = imm_b; op1_sel_o = OP1_RS1; op2_sel_o = OP2_RS2;
                uses_rs1_o = 1'b1; uses_rs2_o = 1'b1;
            end
            INST_JAL: begin
                imm32 = imm_j; op1_sel_o = OP1_PC; op2_sel_o = OP2_FOUR; writes = 1'b1;
            end
            INST_JALR: begin
                legal = (funct3 == F3_JALR);
                imm32 = imm_i; op1_sel_o = OP1_PC; op2_sel_o = OP2_FOUR;
                rs2v_rs1_o = 1'b1; uses_rs1_o = 1'b1; writes = 1'b1;
            end
            INST_LUI: begin
                imm32 = imm_u; op1_sel_o = OP1_ZERO; op2_sel_o = OP2_IMM; writes = 1'b1;
            end
            INST_AUIPC: begin
                imm32 = imm_u; op1_sel_o = OP1_PC; op2_sel_o = OP2_IMM; writes = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            op1_sel_o  = OP1_ZERO;
            op2_sel_o  = OP2_ZERO;
            rs2v_rs1_o = 1'b0;
            uses_rs1_o = 1'b0;
            uses_rs2_o = 1'b0;
            writes     = 1'b0;
        end
    end

    assign imm_o     = XLEN'($signed(imm32));
    assign illegal_o = !legal;
    assign reg_wen_o = writes && (rd_raw != '0);
    assign rd_addr_o = reg_wen_o ? rd_raw : '0;

endmodule

// File: rtl/id_stage.sv
// Registered RV32I decode stage with EX forwarding, load-use interlock, flush and optional skid.
// Latency: 1 cycle from accept to out_valid_o.
// Backpressure: output held while stalled; skid parks one beat so in_ready_o depends only on state.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = 5,
    parameter bit SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        inst_i,
    input  logic [XLEN-1:0]    inst_addr_i,
    output logic [RADDR_W-1:0] rs1_addr_o,
    output logic [RADDR_W-1:0] rs2_addr_o,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [XLEN-1:0]    rs2_data_i,
    input  logic [RADDR_W-1:0] ex_rd_addr_i,
    input  logic               ex_wen_i,
    input  logic               ex_load_i,
    input  logic [XLEN-1:0]    ex_result_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [31:0]        inst_o,
    output logic [XLEN-1:0]    inst_addr_o,
    output logic [XLEN-1:0]    op1_o,
    output logic [XLEN-1:0]    op2_o,
    output logic [XLEN-1:0]    imm_o,
    output logic [XLEN-1:0]    rs2_val_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               reg_wen_o,
    output logic               illegal_o
);
    typedef struct packed {
        logic [31:0]        inst;
        logic [XLEN-1:0]    addr;
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    rs2_val;
        logic [RADDR_W-1:0] rd;
        logic               wen;
        logic               illegal;
    } beat_t;

    logic [RADDR_W-1:0] rs1_addr, rs2_addr, dec_rd;
    logic [XLEN-1:0]    dec_imm, fwd1, fwd2;
    op1_sel_e           op1_sel;
    op2_sel_e           op2_sel;
    logic               rs2v_rs1, uses_rs1, uses_rs2, dec_wen, dec_illegal;
    logic               load_use, accept, out_free;
    logic               out_vld, skid_vld;
    beat_t              new_beat, out_q, skid_q;

    assign rs1_addr   = inst_i[15 +: RADDR_W];
    assign rs2_addr   = inst_i[20 +: RADDR_W];
    assign rs1_addr_o = rs1_addr;
    assign rs2_addr_o = rs2_addr;

    id_decode #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_decode (
        .inst_i     (inst_i),
        .imm_o      (dec_imm),
        .op1_sel_o  (op1_sel),
        .op2_sel_o  (op2_sel),
        .rs2v_rs1_o (rs2v_rs1),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2),
        .rd_addr_o  (dec_rd),
        .reg_wen_o  (dec_wen),
        .illegal_o  (dec_illegal)
    );

    // A load in EX has no result yet, so it is never a forwarding source.
    assign fwd1 = (rs1_addr == '0) ? '0 :
                  (ex_wen_i && !ex_load_i && ex_rd_addr_i == rs1_addr) ? ex_result_i : rs1_data_i;
    assign fwd2 = (rs2_addr == '0) ? '0 :
                  (ex_wen_i && !ex_load_i && ex_rd_addr_i == rs2_addr) ? ex_result_i : rs2_data_i;

    assign load_use = ex_load_i && ex_wen_i && (ex_rd_addr_i != '0) &&
                      ((uses_rs1 && ex_rd_addr_i == rs1_addr) ||
                       (uses_rs2 && ex_rd_addr_i == rs2_addr));

    assign out_free   = !out_vld || out_ready_i;
    assign in_ready_o = (SKID_EN ? !skid_vld : out_free) && !load_use && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        new_beat         = '0;
        new_beat.inst    = inst_i;
        new_beat.addr    = inst_addr_i;
        new_beat.imm     = dec_imm;
        new_beat.rs2_val = rs2v_rs1 ? fwd1 : fwd2;
        new_beat.rd      = dec_rd;
        new_beat.wen     = dec_wen;
        new_beat.illegal = dec_illegal;
        case (op1_sel)
            OP1_RS1: new_beat.op1 = fwd1;
            OP1_PC:  new_beat.op1 = inst_addr_i;
            default: new_beat.op1 = '0;
        endcase
        case (op2_sel)
            OP2_RS2:  new_beat.op2 = fwd2;
            OP2_IMM:  new_beat.op2 = dec_imm;
            OP2_FOUR: new_beat.op2 = XLEN'(4);
            default:  new_beat.op2 = '0;
        endcase
    end

    // The skid is drained before new input is taken, so beat order is preserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else if (flush_i) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (out_free) begin
            if (skid_vld) begin
                out_q    <= skid_q;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                out_vld <= accept;
                if (accept) out_q <= new_beat;
            end
        end else if (SKID_EN && accept) begin
            skid_q   <= new_beat;
            skid_vld <= 1'b1;
        end
    end

    assign out_valid_o = out_vld;
    assign inst_o      = out_q.inst;
    assign inst_addr_o = out_q.addr;
    assign op1_o       = out_q.op1;
    assign op2_o       = out_q.op2;
    assign imm_o       = out_q.imm;
    assign rs2_val_o   = out_q.rs2_val;
    assign rd_addr_o   = out_q.rd;
    assign reg_wen_o   = out_q.wen;
    assign illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage (SKID_EN=1); regfile modelled as rf_val(addr).
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] inst, pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_wen, ex_load;
    logic [31:0] ex_result;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] inst_o, addr_o, op1, op2, imm, rs2v;
    logic [4:0]  rd;
    logic        wen, ill;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst, pc, op1, op2, imm, rs2v;
        logic [4:0]  rd;
        logic        wen, ill, chk_rs2v;
    } vec_t;

    always #5 clk = ~clk;

    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return 32'hA000_0000 + 32'(a) * 32'h11;
    endfunction

    assign rs1_data = rf_val(rs1_addr);
    assign rs2_data = rf_val(rs2_addr);

    id_stage #(.XLEN(32), .RADDR_W(5), .SKID_EN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .inst_i       (inst),
        .inst_addr_i  (pc),
        .rs1_addr_o   (rs1_addr),
        .rs2_addr_o   (rs2_addr),
        .rs1_data_i   (rs1_data),
        .rs2_data_i   (rs2_data),
        .ex_rd_addr_i (ex_rd),
        .ex_wen_i     (ex_wen),
        .ex_load_i    (ex_load),
        .ex_result_i  (ex_result),
        .flush_i      (flush),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .inst_o       (inst_o),
        .inst_addr_o  (addr_o),
        .op1_o        (op1),
        .op2_o        (op2),
        .imm_o        (imm),
        .rs2_val_o    (rs2v),
        .rd_addr_o    (rd),
        .reg_wen_o    (wen),
        .illegal_o    (ill)
    );

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; inst = '0; pc = '0; ex_rd = '0; ex_wen = 1'b0;
        ex_load = 1'b0; ex_result = '0; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (op1 !== 32'h0) begin errors++; $display("FAIL reset_op1: got %h want 0", op1); end
        checks++; if (wen !== 1'b0 || ill !== 1'b0 || inst_o !== 32'h0) begin errors++; $display("FAIL reset_regs: wen %b ill %b inst %h want 0", wen, ill, inst_o); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_addi();
        @(negedge clk);
        in_valid = 1'b1; inst = 32'hFFB00093; pc = 32'h10;
        #1;
        checks++; if (rs1_addr !== 5'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL addi_in: rs1 %0d ready %b want 0/1", rs1_addr, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        checks++; if (op1 !== 32'h0 || op2 !== 32'hFFFFFFFB) begin errors++; $display("FAIL addi_ops: got %h/%h want 0/fffffffb", op1, op2); end
        checks++; if (rd !== 5'd1 || wen !== 1'b1 || addr_o !== 32'h10) begin errors++; $display("FAIL addi_rd: rd %0d wen %b pc %h want 1/1/10", rd, wen, addr_o); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_once: got %b want 0", out_valid); end
    endtask

    task automatic test_forward();
        @(negedge clk);
        ex_wen = 1'b1; ex_load = 1'b0; ex_rd = 5'd1; ex_result = 32'h55;
        in_valid = 1'b1; inst = 32'h002081B3; pc = 32'h14;
        @(negedge clk);
        checks++; if (op1 !== 32'h55 || op2 !== 32'hA0000022 || rd !== 5'd3) begin errors++; $display("FAIL fwd_rs1: got %h/%h rd %0d want 55/a0000022/3", op1, op2, rd); end
        ex_rd = 5'd2; ex_result = 32'h77; pc = 32'h18;
        @(negedge clk);
        checks++; if (op1 !== 32'hA0000011 || op2 !== 32'h77) begin errors++; $display("FAIL fwd_rs2: got %h/%h want a0000011/77", op1, op2); end
        ex_rd = 5'd0; ex_result = 32'h99; inst = 32'hFFB00093; pc = 32'h1C;
        @(negedge clk);
        in_valid = 1'b0; ex_wen = 1'b0;
        checks++; if (out_valid !== 1'b1 || op1 !== 32'h0) begin errors++; $display("FAIL fwd_x0: valid %b op1 %h want 1/0", out_valid, op1); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        ex_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd5;
        in_valid = 1'b1; inst = 32'h00728333; pc = 32'h20;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall: ready %b want 0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: valid %b want 0", out_valid); end
        ex_load = 1'b0; ex_wen = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release: ready %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || op1 !== 32'hA0000055 || op2 !== 32'hA0000077 || rd !== 5'd6) begin errors++; $display("FAIL lu_beat: valid %b ops %h/%h rd %0d want 1/a0000055/a0000077/6", out_valid, op1, op2, rd); end
    endtask

    task automatic test_skid();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00100093; pc = 32'h20;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || inst_o !== 32'h00100093) begin errors++; $display("FAIL skid_a: valid %b inst %h want 1/00100093", out_valid, inst_o); end
        inst = 32'h00200113; pc = 32'h24;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_room: ready %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || inst_o !== 32'h00100093) begin errors++; $display("FAIL skid_full: ready %b inst %h want 0/00100093", in_ready, inst_o); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || addr_o !== 32'h20) begin errors++; $display("FAIL skid_hold: valid %b pc %h want 1/20", out_valid, addr_o); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || addr_o !== 32'h24 || op2 !== 32'h2) begin errors++; $display("FAIL skid_b: valid %b pc %h op2 %h want 1/24/2", out_valid, addr_o, op2); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_drain: valid %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        in_valid = 1'b1; inst = 32'h00100093; pc = 32'h30; flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_block: ready %b want 0", in_ready); end
        @(negedge clk);
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_noaccept: valid %b want 0", out_valid); end
        out_ready = 1'b0;
        @(negedge clk);
        inst = 32'h00200113; pc = 32'h34;
        @(negedge clk);
        inst = 32'h123453B7; pc = 32'h38; flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_stall_block: ready %b want 0", in_ready); end
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1; inst = 32'h00300193; pc = 32'h3C;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: valid %b want 0", out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || addr_o !== 32'h3C) begin errors++; $display("FAIL flush_next: valid %b pc %h want 1/3c", out_valid, addr_o); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost: valid %b want 0", out_valid); end
    endtask

    task automatic test_decode();
        vec_t v[8];
        v[0] = '{32'hFE208CE3, 32'h40, 32'hA0000011, 32'hA0000022, 32'hFFFFFFF8, 32'hA0000022, 5'd0, 1'b0, 1'b0, 1'b1};
        v[1] = '{32'h0000007F, 32'h44, 32'h0,        32'h0,        32'h0,        32'h0,        5'd0, 1'b0, 1'b1, 1'b0};
        v[2] = '{32'h123453B7, 32'h48, 32'h0,        32'h12345000, 32'h12345000, 32'h0,        5'd7, 1'b1, 1'b0, 1'b0};
        v[3] = '{32'h010000EF, 32'h80, 32'h80,       32'h4,        32'h10,       32'h0,        5'd1, 1'b1, 1'b0, 1'b0};
        v[4] = '{32'h0020A423, 32'h84, 32'hA0000011, 32'h8,        32'h8,        32'hA0000022, 5'd0, 1'b0, 1'b0, 1'b1};
        v[5] = '{32'h00008067, 32'h88, 32'h88,       32'h4,        32'h0,        32'hA0000011, 5'd0, 1'b0, 1'b0, 1'b1};
        v[6] = '{32'h00001217, 32'h8C, 32'h8C,       32'h1000,     32'h1000,     32'h0,        5'd4, 1'b1, 1'b0, 1'b0};
        v[7] = '{32'h0000B283, 32'h90, 32'h0,        32'h0,        32'h0,        32'h0,        5'd0, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; inst = v[i].inst; pc = v[i].pc;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || op1 !== v[i].op1 || op2 !== v[i].op2) begin errors++; $display("FAIL dec%0d_ops: valid %b ops %h/%h want 1/%h/%h", i, out_valid, op1, op2, v[i].op1, v[i].op2); end
            checks++; if (rd !== v[i].rd || wen !== v[i].wen || ill !== v[i].ill) begin errors++; $display("FAIL dec%0d_ctl: rd %0d wen %b ill %b want %0d/%b/%b", i, rd, wen, ill, v[i].rd, v[i].wen, v[i].ill); end
            if (!v[i].ill) begin
                checks++; if (imm !== v[i].imm) begin errors++; $display("FAIL dec%0d_imm: got %h want %h", i, imm, v[i].imm); end
            end
            if (v[i].chk_rs2v) begin
                checks++; if (rs2v !== v[i].rs2v) begin errors++; $display("FAIL dec%0d_rs2v: got %h want %h", i, rs2v, v[i].rs2v); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00100093; pc = 32'h50;
        @(negedge clk);
        inst = 32'h00200113; pc = 32'h54;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: valid %b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_async: valid %b want 0", out_valid); end
        #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_skid: valid %b ready %b want 0/1", out_valid, in_ready); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_forward();
        test_load_use();
        test_skid();
        test_flush();
        test_decode();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
